imm_encoder: RTL
================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock; all state changes on this edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  in_value offered.
REQ-004 SHALL have: in_value  input  8  constant to encode, taken modulo 256.
REQ-005 SHALL have: in_ready  output  1  block can accept a constant.
REQ-006 SHALL have: out_valid  output  1  out_imm holds a digit.
REQ-007 SHALL have: out_ready  input  1  consumer accepts the digit.
REQ-008 SHALL have: out_imm  output  2  signed radix-4 digit: 00=0, 01=+1, 10=-2, 11=-1.
REQ-009 SHALL have: out_last  output  1  current digit is the final one of the constant.
REQ-010 SHALL have: out_count  output  3  digit count for the current constant (1..4); 0 outside EMIT.
REQ-011 SHALL have: busy  output  1  high in CONV or EMIT.

Function
REQ-012 SHALL encode each constant V as digits d3..d0, each in {-2,-1,0,+1}, where V ≡ sum(di*4^i) mod 256.
REQ-013 SHALL use three states: IDLE, CONV, EMIT.
REQ-014 SHALL assert in_ready only in IDLE; accept on the edge where in_valid and in_ready are both high.
REQ-015 On accept, SHALL load residue r <= in_value, clear step counter to 0, and enter CONV.
REQ-016 SHALL compute one digit per CONV cycle, LSB first: di = map(r[1:0]) with 0->0, 1->+1, 2->-2, 3->-1; r <= (r - sext8(di)) arithmetic-shifted right by 2, all in 8-bit wrap arithmetic.
REQ-017 SHALL spend exactly 4 cycles in CONV; after the step-3 edge, discard the final residue and enter EMIT.
REQ-018 On entering EMIT, SHALL set the emit pointer to the highest index with a nonzero digit, or 0 if all digits are zero; out_count = pointer+1.
REQ-019 SHALL emit MSB first: out_imm = d[pointer], and hold out_valid high for the whole of EMIT.
REQ-020 SHALL assert out_last when pointer == 0.
REQ-021 On a transfer (out_valid and out_ready), SHALL decrement the pointer; if out_last was high, return to IDLE.
REQ-022 While out_ready is low, SHALL hold out_imm, out_last, and out_count stable.
REQ-023 Consumer reconstruction rule: acc <= acc*4 + sext8(out_imm), mod 256, starting from 0, SHALL recover V.
REQ-024 Timing: with out_ready held high, the first digit SHALL be valid in the cycle after the 5th edge counting the accept edge; then 1 digit per cycle, no bubbles.
REQ-025 Back-to-back: in_ready SHALL rise in the cycle after the last transfer, with no overlap of constants.
REQ-026 Changes on in_value or in_valid while not in IDLE SHALL be ignored.

Reset
REQ-027 Reset SHALL force IDLE asynchronously, at any time including mid-CONV or mid-EMIT.
REQ-028 Reset SHALL set in_ready=1 (combinational from IDLE once reset is released; 0 while reset is high), out_valid=0, out_imm=00, out_last=0, out_count=0, busy=0, and clear digits, residue, step and pointer to 0.
REQ-029 A partially emitted constant SHALL be dropped on reset and SHALL NOT resume.

Verification
REQ-030 0x00 -> one digit 00, out_last=1, out_count=1.
REQ-031 0x7F -> digits 10,00,00,11 (last on 11), out_count=4; 0x80 -> 10,00,00,00; 0x55 -> 01,01,01,01.
REQ-032 0x05 -> 01,01 (count 2); 0xFE -> single 10; 0xFF -> single 11.
REQ-033 Backpressure on 0x7F: drop out_ready for 3 cycles at digit 2 -> out_imm=00 held, out_valid stays 1, stream unchanged on resume.
REQ-034 Reset pulse on the 2nd CONV cycle and again on the 2nd EMIT digit -> next cycle IDLE, all outputs at reset values; a following 0x05 encodes correctly.
REQ-035 Exhaustive: all 256 values streamed back-to-back with random out_ready -> per-constant reconstruction (REQ-023) equals the input, digit count is minimal, and in_ready is never high while busy.

Source files
------------

// File: rtl/imm_encoder.sv
// Recodes an 8-bit constant into signed radix-4 digits {-2,-1,0,+1}, LSB-first
// conversion over four cycles, then streams the minimal digit string MSB-first.
module imm_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_value,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_imm,
    output logic       out_last,
    output logic [2:0] out_count,
    output logic       busy
);

    localparam int unsigned VW = 8;
    localparam int unsigned DW = 2;
    localparam int unsigned ND = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                state;
    logic [VW-1:0]         residue;
    logic [1:0]            step;
    logic [1:0]            ptr;
    logic [ND-1:0][DW-1:0] digits;

    logic [DW-1:0]         digit_c;
    logic [VW-1:0]         diff_c;
    logic [VW-1:0]         residue_next_c;
    logic [ND-1:0][DW-1:0] digits_next_c;
    logic [1:0]            top_c;

    // The digit code equals the residue's low two bits; subtract its signed value and shift.
    always_comb begin
        digit_c        = residue[1:0];
        diff_c         = residue - {{(VW-DW){digit_c[1]}}, digit_c};
        residue_next_c = {{2{diff_c[VW-1]}}, diff_c[VW-1:2]};
        digits_next_c  = digits;
        digits_next_c[step] = digit_c;
    end

    // Highest nonzero digit index decides how many digits are emitted.
    always_comb begin
        top_c = 2'd0;
        for (int i = 1; i < ND; i++) begin
            if (digits_next_c[i] != 2'b00) begin
                top_c = 2'(i);
            end
        end
    end

    assign in_ready = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            residue   <= '0;
            step      <= '0;
            ptr       <= '0;
            digits    <= '0;
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        residue <= in_value;
                        step    <= 2'd0;
                        digits  <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    digits  <= digits_next_c;
                    residue <= residue_next_c;
                    step    <= step + 2'd1;
                    if (step == 2'd3) begin
                        residue   <= '0;
                        ptr       <= top_c;
                        out_valid <= 1'b1;
                        out_imm   <= digits_next_c[top_c];
                        out_last  <= (top_c == 2'd0);
                        out_count <= 3'(top_c) + 3'd1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_imm   <= '0;
                            out_last  <= 1'b0;
                            out_count <= '0;
                            ptr       <= '0;
                            state     <= IDLE;
                        end else begin
                            ptr      <= ptr - 2'd1;
                            out_imm  <= digits[ptr - 2'd1];
                            out_last <= (ptr == 2'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
